// File: rtl/countdown_timer.sv
// Countdown timer with a valid/ready load port. A start value is loaded and the
// count is decremented by max(step,1) each running cycle. The count clamps at
// TARGET, and reaching it produces a one-cycle done pulse.
//
// Handshake: a load transfers on a rising edge where load_valid_i && load_ready_o.
// load_ready_o depends only on state: it is high in IDLE and DONE and low in RUN.
// The requester may hold load_valid_i until the transfer. load_value_i is sampled
// only on the transfer edge.
module countdown_timer #(
  parameter int WIDTH  = 16,
  parameter int TARGET = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [2:0]       step_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Terminal value at counter width and at the widened compare width.
  localparam logic [WIDTH-1:0] TargetW = WIDTH'(TARGET);
  localparam logic [WIDTH+1:0] TargetX = (WIDTH + 2)'(TARGET);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       step_eff_d;
  logic [WIDTH+1:0] limit_d;
  logic             reach_d;
  logic [WIDTH-1:0] count_dec_d;

  // Effective step and terminal test. The compare runs two bits wider, so
  // TARGET + step can never wrap and the count cannot fall below TARGET.
  always_comb begin
    step_eff_d  = (step_i == 3'd0) ? 3'd1 : step_i;
    limit_d     = TargetX + (WIDTH + 2)'(step_eff_d);
    reach_d     = ({2'b00, count_q} <= limit_d);
    count_dec_d = count_q - WIDTH'(step_eff_d);
  end

  // Control FSM with registered count, busy and done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A load here begins a run at once. This includes a back-to-back load from DONE.
          done_q <= 1'b0;
          if (load_valid_i) begin
            state_q <= S_RUN;
            count_q <= load_value_i;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            // Abort wins over pause and decrement. The count is kept and no done pulse occurs.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (pause_i) begin
            state_q <= S_RUN;
          end else if (reach_d) begin
            state_q <= S_DONE;
            count_q <= TargetW;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_dec_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o = (state_q != S_RUN);
  assign count_o      = count_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign state_o      = state_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 16, counter width in bits.
REQ-002 Parameter TARGET, default 0, terminal count value; SHALL satisfy TARGET < 2^WIDTH - 1.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  requester offers a start value.
REQ-006 load_ready  output  1  block can accept a start value.
REQ-007 load_value  input  WIDTH  start value, sampled on an accepted load.
REQ-008 step  input  3  per-cycle decrement; value 0 SHALL be treated as 1.
REQ-009 pause  input  1  freezes count while running.
REQ-010 abort  input  1  cancels a run.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle completion pulse, registered.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-015 load_ready SHALL be high in IDLE and DONE, and low in RUN.
REQ-016 A load is accepted on an edge where load_valid && load_ready. On that edge, count <= load_value and state <= RUN.
REQ-017 In RUN with abort=0 and pause=1, count and state SHALL hold.
REQ-018 In RUN with abort=0 and pause=0, let s = max(step,1):
  - if count <= TARGET + s, computed at WIDTH+2 bits with no wrap: count <= TARGET and state <= DONE;
  - otherwise count <= count - s.
REQ-019 count SHALL never wrap below TARGET, including when load_value <= TARGET. In that case the first RUN cycle moves count to TARGET and enters DONE.
REQ-020 abort in RUN SHALL take priority over pause and decrement: state <= IDLE, count holds, no done pulse.
REQ-021 abort SHALL be ignored in IDLE and DONE.
REQ-022 done SHALL be high exactly in the DONE state, which lasts one cycle. DONE then goes to IDLE, or to RUN if a load is accepted in DONE (back-to-back, no idle cycle).
REQ-023 busy SHALL equal (state == RUN).
REQ-024 Latency: with no pause, a load of V accepted at edge e0 gives RUN for ceil((V - TARGET)/s) cycles (minimum 1), then done for one cycle. Each paused cycle SHALL add exactly one cycle.
REQ-025 step SHALL be sampled every RUN cycle, so a change takes effect on the next decrement.
REQ-026 In IDLE, count SHALL hold its last value.

Reset
REQ-027 While reset=0, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, count=0, done=0 and busy=0, with load_ready=1.
REQ-028 Reset asserted mid-run SHALL discard the run without a done pulse.
REQ-029 The first load SHALL be accepted no earlier than the first rising edge after reset deasserts.

Verification (WIDTH=16, TARGET=0 unless stated)
REQ-030 Load 6, step 1 -> count 6,5,4,3,2,1 over 6 RUN cycles, then count 0 with done=1 for one cycle, then IDLE with load_ready=1.
REQ-031 Load 10, step 4 -> count 10,6,2 over 3 RUN cycles, then count 0, done pulse; load 0xFFFF, step 7 -> no wrap, final count 0.
REQ-032 Load 6, step 1, pause=1 for 3 cycles at count 4 -> count holds 4 for those cycles; done arrives exactly 3 cycles later than in REQ-030.
REQ-033 Load 6, abort at count 3 -> next cycle IDLE, count 3, busy 0, done never asserted; abort while IDLE has no effect.
REQ-034 reset driven to 0 mid-run at count 5, with no clock edge -> count 0, busy 0, done 0, load_ready 1 immediately; release reset and load 2 -> normal run.
REQ-035 Back-to-back load of 3 presented during DONE -> accepted, RUN begins next cycle with count 3, no IDLE cycle; TARGET=6 with load 4 -> one RUN cycle, count 6, done pulse.
